// File: rtl/alu_seq_unit.sv
`default_nettype none
// alu_seq_unit: handshaked ALU with single-cycle ops and a restoring unsigned
// divider that writes Hi/Lo; each result is published with a one-cycle done pulse.
module alu_seq_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam logic [5:0] OP_ADD  = 6'd32;
  localparam logic [5:0] OP_SUB  = 6'd34;
  localparam logic [5:0] OP_AND  = 6'd36;
  localparam logic [5:0] OP_OR   = 6'd37;
  localparam logic [5:0] OP_SLT  = 6'd42;
  localparam logic [5:0] OP_SRL  = 6'd2;
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_MFHI = 6'd16;
  localparam logic [5:0] OP_MFLO = 6'd18;

  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;
  logic [WIDTH:0]     trial;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    result_d   = result_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ill_d      = ill_q;
    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    trial      = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d    = 1'b0;
          ill_d    = 1'b0;
          result_d = '0;
          state_d  = S_DONE;
          case (signal)
            OP_ADD:  result_d = data_a + data_b;
            OP_SUB:  result_d = data_a - data_b;
            OP_AND:  result_d = data_a & data_b;
            OP_OR:   result_d = data_a | data_b;
            OP_SLT:  result_d = ($signed(data_a) < $signed(data_b)) ? WIDTH'(1) : '0;
            OP_SRL:  result_d = data_a >> data_b[SHAMT_W-1:0];
            OP_MFHI: result_d = hi_q;
            OP_MFLO: result_d = lo_q;
            OP_DIVU: begin
              if (data_b == '0) begin
                result_d = '1;
                lo_d     = '1;
                hi_d     = data_a;
                dbz_d    = 1'b1;
              end else begin
                state_d   = S_DIV;
                count_d   = '0;
                rem_d     = '0;
                quo_d     = data_a;
                divisor_d = data_b;
              end
            end
            default: ill_d = 1'b1;
          endcase
        end
      end

      S_DIV: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d  = S_DONE;
          lo_d     = quo_d;
          hi_d     = rem_d;
          result_d = quo_d;
        end
      end

      S_DONE: begin
        data_out_d = result_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      result_q   <= result_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ill_q      <= ill_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign data_out    = data_out_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// tb_alu_seq_unit: directed and randomized checks of alu_seq_unit at WIDTH=32
// and WIDTH=16 against an arithmetic reference model with shadow Hi/Lo.
module tb_alu_seq_unit;

  localparam logic [5:0] OP_ADD  = 6'd32;
  localparam logic [5:0] OP_SUB  = 6'd34;
  localparam logic [5:0] OP_AND  = 6'd36;
  localparam logic [5:0] OP_OR   = 6'd37;
  localparam logic [5:0] OP_SLT  = 6'd42;
  localparam logic [5:0] OP_SRL  = 6'd2;
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_MFHI = 6'd16;
  localparam logic [5:0] OP_MFLO = 6'd18;
  localparam logic [5:0] OP_BAD  = 6'd63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, busy32, done32, dbz32, ill32;
  logic [5:0]  sig32;
  logic [31:0] a32, b32, out32;
  logic        start16, busy16, done16, dbz16, ill16;
  logic [5:0]  sig16;
  logic [15:0] a16, b16, out16;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_seq_unit #(.WIDTH(32), .SHAMT_W(5)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .signal(sig32),
    .data_a(a32), .data_b(b32), .busy(busy32), .done(done32),
    .data_out(out32), .div_by_zero(dbz32), .illegal_op(ill32)
  );

  alu_seq_unit #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .signal(sig16),
    .data_a(a16), .data_b(b16), .busy(busy16), .done(done16),
    .data_out(out16), .div_by_zero(dbz16), .illegal_op(ill16)
  );

  // Reference model: operation semantics straight from the arithmetic rules.
  task automatic model32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] exp, output int exp_lat,
                         output logic exp_dbz, output logic exp_ill);
    exp = '0; exp_lat = 2; exp_dbz = 1'b0; exp_ill = 1'b0;
    case (op)
      OP_ADD:  exp = a + b;
      OP_SUB:  exp = a - b;
      OP_AND:  exp = a & b;
      OP_OR:   exp = a | b;
      OP_SLT:  exp = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SRL:  exp = a >> b[4:0];
      OP_MFHI: exp = m_hi;
      OP_MFLO: exp = m_lo;
      OP_DIVU: begin
        if (b == 0) begin
          exp = '1; m_lo = '1; m_hi = a; exp_dbz = 1'b1;
        end else begin
          exp = a / b; m_lo = a / b; m_hi = a % b; exp_lat = 34;
        end
      end
      default: exp_ill = 1'b1;
    endcase
  endtask

  // Drive one request and wait (bounded) for done; lat counts negedges after the sampling edge.
  task automatic issue32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] exp, output int exp_lat,
                         output logic exp_dbz, output logic exp_ill);
    model32(op, a, b, exp, exp_lat, exp_dbz, exp_ill);
    @(negedge clk);
    sig32 = op; a32 = a; b32 = b; start32 = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      start32 = 1'b0;
      lat++;
    end while (done32 !== 1'b1 && lat < 100);
  endtask

  task automatic test_reset;
    int seen_done = 0;
    int lat, elat;
    logic [31:0] exp;
    logic edbz, eill;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy32, done32, dbz32, ill32, out32} !== 36'd0) begin
      bad++; $display("FAIL reset_state: got %h want 0", {busy32, done32, dbz32, ill32, out32});
    end
    reset = 1'b1;
    @(negedge clk);
    sig32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) begin @(negedge clk); if (done32) seen_done++; end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin @(negedge clk); if (done32) seen_done++; end
    total++;
    if (busy32 !== 1'b0) begin bad++; $display("FAIL reset_abort_busy: got %b want 0", busy32); end
    total++;
    if (seen_done != 0) begin bad++; $display("FAIL reset_abort_done: got %0d pulses want 0", seen_done); end
    m_hi = '0; m_lo = '0;
    issue32(OP_MFLO, 32'd0, 32'd0, lat, exp, elat, edbz, eill);
    total++;
    if (out32 !== 32'd0) begin bad++; $display("FAIL reset_mflo: got %h want 0", out32); end
  endtask

  task automatic test_add_sub;
    int lat, elat;
    logic [31:0] exp;
    logic edbz, eill;
    issue32(OP_ADD, 32'hFFFF_FFFF, 32'd1, lat, exp, elat, edbz, eill);
    total++;
    if (lat != 2) begin bad++; $display("FAIL add_latency: got %0d want 2", lat); end
    total++;
    if (out32 !== 32'd0) begin bad++; $display("FAIL add_wrap: got %h want 0", out32); end
    @(negedge clk);
    total++;
    if (done32 !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done32); end
    repeat (3) @(negedge clk);
    total++;
    if (out32 !== 32'd0) begin bad++; $display("FAIL data_out_hold: got %h want 0", out32); end
    issue32(OP_SUB, 32'd0, 32'd1, lat, exp, elat, edbz, eill);
    total++;
    if (out32 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sub_wrap: got %h want ffffffff", out32); end
  endtask

  task automatic test_slt_srl;
    int lat, elat;
    logic [31:0] exp;
    logic edbz, eill;
    issue32(OP_SLT, 32'hFFFF_FFFE, 32'd1, lat, exp, elat, edbz, eill);
    total++;
    if (out32 !== 32'd1) begin bad++; $display("FAIL slt_signed: got %h want 1", out32); end
    issue32(OP_SRL, 32'h8000_0000, 32'h0000_0104, lat, exp, elat, edbz, eill);
    total++;
    if (out32 !== 32'h0800_0000) begin bad++; $display("FAIL srl_shamt: got %h want 08000000", out32); end
  endtask

  task automatic test_divu;
    int lat, elat;
    logic [31:0] exp;
    logic edbz, eill;
    issue32(OP_DIVU, 32'd100, 32'd7, lat, exp, elat, edbz, eill);
    total++;
    if (lat != 34) begin bad++; $display("FAIL divu_latency: got %0d want 34", lat); end
    total++;
    if (out32 !== 32'd14) begin bad++; $display("FAIL divu_quotient: got %h want e", out32); end
    issue32(OP_MFHI, 32'd0, 32'd0, lat, exp, elat, edbz, eill);
    total++;
    if (out32 !== 32'd2) begin bad++; $display("FAIL divu_mfhi: got %h want 2", out32); end
    issue32(OP_MFLO, 32'd0, 32'd0, lat, exp, elat, edbz, eill);
    total++;
    if (out32 !== 32'd14) begin bad++; $display("FAIL divu_mflo: got %h want e", out32); end
  endtask

  task automatic test_div_zero;
    int lat, elat;
    logic [31:0] exp;
    logic edbz, eill;
    issue32(OP_DIVU, 32'd5, 32'd0, lat, exp, elat, edbz, eill);
    total++;
    if (lat != 2) begin bad++; $display("FAIL dbz_latency: got %0d want 2", lat); end
    total++;
    if (out32 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_result: got %h want ffffffff", out32); end
    total++;
    if (dbz32 !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", dbz32); end
    issue32(OP_ADD, 32'd3, 32'd4, lat, exp, elat, edbz, eill);
    total++;
    if (dbz32 !== 1'b0 || out32 !== 32'd7) begin
      bad++; $display("FAIL dbz_clear: got flag=%b out=%h want flag=0 out=7", dbz32, out32);
    end
    issue32(OP_MFHI, 32'd0, 32'd0, lat, exp, elat, edbz, eill);
    total++;
    if (out32 !== 32'd5) begin bad++; $display("FAIL dbz_mfhi: got %h want 5", out32); end
  endtask

  task automatic test_illegal;
    int lat, elat;
    logic [31:0] exp;
    logic edbz, eill;
    issue32(OP_BAD, 32'h1234_5678, 32'h9ABC_DEF0, lat, exp, elat, edbz, eill);
    total++;
    if (out32 !== 32'd0 || ill32 !== 1'b1 || lat != 2) begin
      bad++; $display("FAIL illegal_op: got out=%h flag=%b lat=%0d want out=0 flag=1 lat=2", out32, ill32, lat);
    end
    issue32(OP_OR, 32'hF0, 32'h0F, lat, exp, elat, edbz, eill);
    total++;
    if (ill32 !== 1'b0 || out32 !== 32'hFF) begin
      bad++; $display("FAIL illegal_clear: got flag=%b out=%h want flag=0 out=ff", ill32, out32);
    end
  endtask

  task automatic test_ignore_start;
    int lat = 0;
    @(negedge clk);
    sig32 = OP_DIVU; a32 = 32'd1000; b32 = 32'd10; start32 = 1'b1;
    @(posedge clk);
    m_lo = 32'd100; m_hi = 32'd0;
    do begin
      @(negedge clk);
      lat++;
      start32 = (lat < 30) ? lat[0] : 1'b0;
      sig32   = lat[1] ? OP_BAD : OP_ADD;
      a32 = $urandom; b32 = $urandom;
    end while (done32 !== 1'b1 && lat < 100);
    start32 = 1'b0;
    total++;
    if (lat != 34 || out32 !== 32'd100) begin
      bad++; $display("FAIL ignore_start: got lat=%0d out=%h want lat=34 out=64", lat, out32);
    end
    total++;
    if (ill32 !== 1'b0 || dbz32 !== 1'b0) begin
      bad++; $display("FAIL ignore_start_flags: got ill=%b dbz=%b want 0 0", ill32, dbz32);
    end
  endtask

  task automatic test_random;
    logic [5:0] ops [10];
    logic [5:0] op;
    logic [31:0] a, b, exp;
    logic edbz, eill;
    int lat, elat;
    ops[0] = OP_ADD;  ops[1] = OP_SUB;  ops[2] = OP_AND;  ops[3] = OP_OR;
    ops[4] = OP_SLT;  ops[5] = OP_SRL;  ops[6] = OP_DIVU; ops[7] = OP_MFHI;
    ops[8] = OP_MFLO; ops[9] = OP_BAD;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue32(op, a, b, lat, exp, elat, edbz, eill);
      total++;
      if (out32 !== exp || lat != elat || dbz32 !== edbz || ill32 !== eill) begin
        bad++;
        $display("FAIL random_op[%0d] op=%0d a=%h b=%h: got out=%h lat=%0d dbz=%b ill=%b want out=%h lat=%0d dbz=%b ill=%b",
                 i, op, a, b, out32, lat, dbz32, ill32, exp, elat, edbz, eill);
      end
    end
  endtask

  task automatic test_div16;
    int lat;
    logic [15:0] q16;
    logic [5:0] seq [3];
    seq[0] = OP_DIVU; seq[1] = OP_MFHI; seq[2] = OP_MFLO;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sig16 = seq[k]; a16 = 16'hFFFF; b16 = 16'h0010; start16 = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
        @(negedge clk);
        start16 = 1'b0;
        lat++;
      end while (done16 !== 1'b1 && lat < 100);
      q16 = out16;
      total++;
      case (k)
        0: if (lat != 18 || q16 !== 16'h0FFF) begin
             bad++; $display("FAIL div16_quotient: got lat=%0d out=%h want lat=18 out=0fff", lat, q16);
           end
        1: if (q16 !== 16'h000F) begin
             bad++; $display("FAIL div16_mfhi: got %h want 000f", q16);
           end
        default: if (q16 !== 16'h0FFF) begin
             bad++; $display("FAIL div16_mflo: got %h want 0fff", q16);
           end
      endcase
    end
  endtask

  initial begin
    reset = 1'b0;
    start32 = 1'b0; sig32 = '0; a32 = '0; b32 = '0;
    start16 = 1'b0; sig16 = '0; a16 = '0; b16 = '0;
    test_reset();
    test_add_sub();
    test_slt_srl();
    test_divu();
    test_div_zero();
    test_illegal();
    test_ignore_start();
    test_random();
    test_div16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
